// File: rtl/cjb_addsub16_seq_if.sv
// Request/result and 8-bit add/sub subunit signals of the 16-bit add/sub sequencer.
// slave = sequencer side; master = requester plus subunit side.
interface cjb_addsub16_seq_if;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        flag_n;
   logic        flag_z;
   logic        flag_c;
   logic        flag_v;
   logic        au_cin;
   logic [7:0]  au_x;
   logic [7:0]  au_y;
   logic [7:0]  au_sum;
   logic        au_cout;
   logic        au_ovf;

   modport slave (
      input  start, op, a, b, au_sum, au_cout, au_ovf,
      output busy, done, result, flag_n, flag_z, flag_c, flag_v, au_cin, au_x, au_y
   );

   modport master (
      output start, op, a, b, au_sum, au_cout, au_ovf,
      input  busy, done, result, flag_n, flag_z, flag_c, flag_v, au_cin, au_x, au_y
   );
endinterface

// File: rtl/cjb_addsub16_seq.sv
// Byte-serial 16-bit add/subtract sequencer driving an 8-bit add/sub subunit (LO then HI pass).
// Optional saturation on signed overflow: define CJB_ADDSUB16_SAT_EN.
module cjb_addsub16_seq (
   input logic                   clock,
   input logic                   resetn,
   cjb_addsub16_seq_if.slave     bus
);
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLo   = 2'd1;
   localparam logic [1:0] StHi   = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]  r_state;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic        r_op;
   logic        r_c_lo;
   logic [15:0] r_result;
   logic        r_flag_n;
   logic        r_flag_z;
   logic        r_flag_c;
   logic        r_flag_v;

   logic [15:0] w_by;
   logic [7:0]  w_by_byte;
   logic        w_cin;
   logic [7:0]  w_x;
   logic [15:0] w_final;

   assign w_by = r_op ? ~r_b : r_b;

   // Subunit XORs y with cin internally; pre-XOR here so it computes x + by_byte + cin.
   always_comb begin
      w_cin     = 1'b0;
      w_x       = 8'h00;
      w_by_byte = 8'h00;
      case (r_state)
         StLo: begin
            w_cin     = r_op;
            w_x       = r_a[7:0];
            w_by_byte = w_by[7:0];
         end
         StHi: begin
            w_cin     = r_c_lo;
            w_x       = r_a[15:8];
            w_by_byte = w_by[15:8];
         end
         default: ;
      endcase
   end

   assign bus.au_cin = w_cin;
   assign bus.au_x   = w_x;
   assign bus.au_y   = w_by_byte ^ {8{w_cin}};

   always_comb begin
      w_final = {bus.au_sum, r_result[7:0]};
`ifdef CJB_ADDSUB16_SAT_EN
      if (bus.au_ovf) begin
         w_final = r_a[15] ? 16'h8000 : 16'h7FFF;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= StIdle;
         r_a      <= 16'h0000;
         r_b      <= 16'h0000;
         r_op     <= 1'b0;
         r_c_lo   <= 1'b0;
         r_result <= 16'h0000;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_v <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_op    <= bus.op;
                  r_state <= StLo;
               end
            end
            StLo: begin
               r_result[7:0] <= bus.au_sum;
               r_c_lo        <= bus.au_cout;
               r_state       <= StHi;
            end
            StHi: begin
               r_result <= w_final;
               r_flag_n <= w_final[15];
               r_flag_z <= (w_final == 16'h0000);
               r_flag_c <= bus.au_cout;
               r_flag_v <= bus.au_ovf;
               r_state  <= StDone;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy   = (r_state != StIdle);
   assign bus.done   = (r_state == StDone);
   assign bus.result = r_result;
   assign bus.flag_n = r_flag_n;
   assign bus.flag_z = r_flag_z;
   assign bus.flag_c = r_flag_c;
   assign bus.flag_v = r_flag_v;
endmodule
